riscv_regfile_mp: RTL and testbench
===================================

RISCV_REGFILE_MP -- requirements
Module: riscv_regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREGS, default 32: register count; power of two, at least 4; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of combinational read ports, 1 to 4.
REQ-004 Parameter BYPASS, default 1: 1 forwards same-cycle write data to the read ports; 0 gives no forwarding.
REQ-005 Port clk_in, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port rst_n_in, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port clear_in, input, 1 bit: request a re-clear of all registers; honoured only in READY.
REQ-008 Port ready_out, output, 1 bit: high when the register file is initialised and usable.
REQ-009 Port rs_addr_in, input, NRD*AW bits: read addresses; port k uses bits [k*AW +: AW].
REQ-010 Port rs_data_out, output, NRD*XLEN bits: read data; port k uses bits [k*XLEN +: XLEN].
REQ-011 Port rd_we_in, input, 1 bit: write enable.
REQ-012 Port rd_addr_in, input, AW bits: write address.
REQ-013 Port rd_data_in, input, XLEN bits: write data.
REQ-014 Port claim_in, input, 1 bit: mark claim_addr_in as having a pending write (scoreboard set).
REQ-015 Port claim_addr_in, input, AW bits: register to claim.
REQ-016 Port flush_in, input, 1 bit: clear all scoreboard busy bits.
REQ-017 Port busy_out, output, NREGS bits: scoreboard; bit i high means register i has a pending write.
REQ-018 Port reg_debug_in, input, AW bits: debug read address.
REQ-019 Port reg_debug_out, output, XLEN bits: debug read data; never bypassed.

Function
REQ-020 The register array shall have no reset and shall map to distributed RAM; initialisation shall be done by a clear FSM with states CLEAR and READY.
REQ-021 In CLEAR, a clear counter starting at 1 shall write 0 to register[counter] each cycle and increment.
REQ-022 After the write to register NREGS-1, the FSM shall go to READY; ready_out shall be high from the following cycle.
REQ-023 CLEAR shall therefore last exactly NREGS-1 cycles after reset is released.
REQ-024 In READY, clear_in=1 shall move the FSM to CLEAR with counter=1 at the next edge, drop ready_out and clear all busy bits.
REQ-025 In CLEAR, rd_we_in, claim_in and clear_in shall be ignored; rs_data_out and reg_debug_out shall read 0.
REQ-026 Register 0 shall always read 0; writes and claims to address 0 shall be discarded.
REQ-027 In READY, rd_we_in=1 with rd_addr_in!=0 shall update register[rd_addr_in] at the edge.
REQ-028 Reads shall be combinational: rs_data_out[k] = register[rs_addr_in[k]].
REQ-029 When BYPASS=1, rd_we_in=1 and rs_addr_in[k]==rd_addr_in!=0, port k shall output rd_data_in in the same cycle.
REQ-030 A write to register r shall clear busy[r] at the edge.
REQ-031 claim_in=1 with claim_addr_in=r!=0 shall set busy[r] at the edge.
REQ-032 If a claim and a write target the same r in one cycle, the claim shall win and busy[r]=1.
REQ-033 flush_in=1 shall clear all busy bits at the edge and take priority over a same-cycle claim.
REQ-034 A same-cycle write while flush_in=1 shall still update the register.
REQ-035 busy_out[0] shall be constant 0.

Reset
REQ-036 When rst_n_in=0, the block shall asynchronously enter: FSM=CLEAR, counter=1, ready_out=0, busy_out=0.
REQ-037 Register contents during reset are don't-care; they are defined only after CLEAR completes.
REQ-038 Reset asserted mid-CLEAR or mid-operation shall restart the full CLEAR sequence on release.

Verification
REQ-039 The bench shall cover: reset release with NREGS=32 -> ready_out rises after 31 cycles; every register reads 0.
REQ-040 The bench shall cover: write x5=0xDEADBEEF with rs_addr[0]=5 in the same cycle, BYPASS=1 -> rs_data_out[0]=0xDEADBEEF that cycle. With BYPASS=0 -> old value that cycle, new value the next cycle.
REQ-041 The bench shall cover: write x0=0x1234 and claim x0 -> x0 reads 0 and busy_out[0]=0.
REQ-042 The bench shall cover: claim x7, then write x7 and claim x7 in the same cycle -> busy_out[7]=1; a later write to x7 alone -> busy_out[7]=0.
REQ-043 The bench shall cover: claim x3 with flush_in=1 in the same cycle -> busy_out=0.
REQ-044 The bench shall cover: clear_in in READY after x9=0x55, then rst_n_in pulsed low mid-CLEAR -> ready_out=0, the CLEAR sequence restarts, and afterwards x9 reads 0.

Source files
------------

// File: rtl/riscv_regfile_mp.sv
// ============================================================================
//  Module   : riscv_regfile_mp
//  Purpose  : Multi-port RISC-V integer register file with scoreboard and
//             clear-FSM initialisation (array itself has no reset).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 clear_in,
    output logic                 ready_out,
    input  logic [NRD*AW-1:0]    rs_addr_in,
    output logic [NRD*XLEN-1:0]  rs_data_out,
    input  logic                 rd_we_in,
    input  logic [AW-1:0]        rd_addr_in,
    input  logic [XLEN-1:0]      rd_data_in,
    input  logic                 claim_in,
    input  logic [AW-1:0]        claim_addr_in,
    input  logic                 flush_in,
    output logic [NREGS-1:0]     busy_out,
    input  logic [AW-1:0]        reg_debug_in,
    output logic [XLEN-1:0]      reg_debug_out
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0] mem_q [NREGS];

    logic            w_ready;
    logic            w_user_we;
    logic            w_claim_ok;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [XLEN-1:0] w_wr_data;

    assign w_ready    = (state_q == ST_READY);
    assign w_user_we  = w_ready && rd_we_in && (rd_addr_in != '0);
    assign w_claim_ok = w_ready && claim_in && (claim_addr_in != '0);

    // The single array write port is shared between the clear sweep and user writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_wr_en   = 1'b0;
        w_wr_addr = cnt_q;
        w_wr_data = '0;
        case (state_q)
            ST_CLEAR: begin
                w_wr_en   = 1'b1;
                w_wr_addr = cnt_q;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = AW'(1);
                end
            end
            ST_READY: begin
                if (w_user_we) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = rd_addr_in;
                    w_wr_data = rd_data_in;
                end
                if (clear_in) begin
                    state_d = ST_CLEAR;
                    cnt_d   = AW'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = AW'(1);
            end
        endcase
    end

    // Claim is applied after the write-clear so it wins; flush/clear override both.
    always_comb begin
        busy_d = busy_q;
        if (w_user_we) begin
            busy_d[rd_addr_in] = 1'b0;
        end
        if (w_claim_ok) begin
            busy_d[claim_addr_in] = 1'b1;
        end
        if (flush_in || (w_ready && clear_in)) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_CLEAR;
            cnt_q   <= AW'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            mem_q[w_wr_addr] <= w_wr_data;
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_raw;
            logic [XLEN-1:0] w_val;

            assign w_addr = rs_addr_in[k*AW +: AW];
            assign w_raw  = (w_addr == '0) ? '0 : mem_q[w_addr];

            if (BYPASS != 0) begin : g_byp
                assign w_val = (w_user_we && (w_addr == rd_addr_in)) ? rd_data_in : w_raw;
            end else begin : g_nobyp
                assign w_val = w_raw;
            end

            assign rs_data_out[k*XLEN +: XLEN] = w_ready ? w_val : '0;
        end
    endgenerate

    assign reg_debug_out = (w_ready && (reg_debug_in != '0)) ? mem_q[reg_debug_in] : '0;
    assign ready_out     = w_ready;
    assign busy_out      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_regfile_mp.sv
// ============================================================================
//  Module   : tb_riscv_regfile_mp
//  Purpose  : Directed self-checking bench; bypass and non-bypass instances
//             share all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        we = 1'b0;
    logic        claim = 1'b0;
    logic        flush = 1'b0;
    logic [9:0]  rs_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [4:0]  claim_addr = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] rd_data = '0;

    logic        ready_b, ready_n;
    logic [63:0] rs_data_b, rs_data_n;
    logic [31:0] busy_b, busy_n;
    logic [31:0] dbg_b, dbg_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_dut_byp (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .ready_out(ready_b),
        .rs_addr_in(rs_addr), .rs_data_out(rs_data_b),
        .rd_we_in(we), .rd_addr_in(rd_addr), .rd_data_in(rd_data),
        .claim_in(claim), .claim_addr_in(claim_addr), .flush_in(flush),
        .busy_out(busy_b), .reg_debug_in(dbg_addr), .reg_debug_out(dbg_b)
    );

    riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_dut_nobyp (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .ready_out(ready_n),
        .rs_addr_in(rs_addr), .rs_data_out(rs_data_n),
        .rd_we_in(we), .rd_addr_in(rd_addr), .rd_data_in(rd_data),
        .claim_in(claim), .claim_addr_in(claim_addr), .flush_in(flush),
        .busy_out(busy_n), .reg_debug_in(dbg_addr), .reg_debug_out(dbg_n)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (ready_b !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        int c;
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (ready_b !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", ready_b); end
        n_cmp++;
        if (busy_b !== 32'h0) begin n_err++; $display("FAIL reset_busy got=%h want=00000000", busy_b); end
        rst_n = 1'b1;
        wait_ready(c);
        n_cmp++;
        if (c != 31) begin n_err++; $display("FAIL reset_clear_cycles got=%0d want=31", c); end
        n_cmp++;
        if (ready_n !== 1'b1) begin n_err++; $display("FAIL reset_ready_nobyp got=%b want=1", ready_n); end
        for (int i = 0; i < 32; i++) begin
            rs_addr  = {5'(31 - i), 5'(i)};
            dbg_addr = 5'(i);
            #1;
            n_cmp++;
            if ({rs_data_b, dbg_b} !== 96'h0) begin
                n_err++;
                $display("FAIL reset_zero_x%0d got=%h_%h want=0", i, rs_data_b, dbg_b);
            end
        end
    endtask

    task automatic test_bypass;
        tick();
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF; rs_addr = {5'd5, 5'd5};
        #1;
        n_cmp++;
        if (rs_data_b[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_p0 got=%h want=deadbeef", rs_data_b[31:0]); end
        n_cmp++;
        if (rs_data_b[63:32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_p1 got=%h want=deadbeef", rs_data_b[63:32]); end
        n_cmp++;
        if (rs_data_n[31:0] !== 32'h0) begin n_err++; $display("FAIL nobypass_old got=%h want=00000000", rs_data_n[31:0]); end
        tick();
        we = 1'b0;
        #1;
        n_cmp++;
        if (rs_data_n[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL nobypass_new got=%h want=deadbeef", rs_data_n[31:0]); end
        n_cmp++;
        if (rs_data_b[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_stored got=%h want=deadbeef", rs_data_b[31:0]); end
    endtask

    task automatic test_debug_no_bypass;
        we = 1'b1; rd_addr = 5'd12; rd_data = 32'hC0FFEE01; rs_addr = {5'd0, 5'd12}; dbg_addr = 5'd12;
        #1;
        n_cmp++;
        if (dbg_b !== 32'h0) begin n_err++; $display("FAIL debug_same_cycle got=%h want=00000000", dbg_b); end
        n_cmp++;
        if (rs_data_b[31:0] !== 32'hC0FFEE01) begin n_err++; $display("FAIL debug_rs_bypass got=%h want=c0ffee01", rs_data_b[31:0]); end
        tick();
        we = 1'b0;
        #1;
        n_cmp++;
        if (dbg_b !== 32'hC0FFEE01) begin n_err++; $display("FAIL debug_after got=%h want=c0ffee01", dbg_b); end
    endtask

    task automatic test_x0;
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'h00001234;
        claim = 1'b1; claim_addr = 5'd0; rs_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
        #1;
        n_cmp++;
        if (rs_data_b !== 64'h0) begin n_err++; $display("FAIL x0_no_bypass got=%h want=0", rs_data_b); end
        tick();
        we = 1'b0; claim = 1'b0;
        #1;
        n_cmp++;
        if (rs_data_b !== 64'h0 || dbg_b !== 32'h0) begin
            n_err++; $display("FAIL x0_read got=%h/%h want=0", rs_data_b, dbg_b);
        end
        n_cmp++;
        if (busy_b !== 32'h0) begin n_err++; $display("FAIL x0_busy got=%h want=00000000", busy_b); end
    endtask

    task automatic test_claim_write;
        claim = 1'b1; claim_addr = 5'd7;
        tick();
        claim = 1'b0;
        #1;
        n_cmp++;
        if (busy_b !== 32'h00000080) begin n_err++; $display("FAIL claim7 got=%h want=00000080", busy_b); end
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h00000077; claim = 1'b1; claim_addr = 5'd7;
        tick();
        we = 1'b0; claim = 1'b0; rs_addr = {5'd0, 5'd7};
        #1;
        n_cmp++;
        if (busy_b !== 32'h00000080) begin n_err++; $display("FAIL claim_wins got=%h want=00000080", busy_b); end
        n_cmp++;
        if (rs_data_b[31:0] !== 32'h00000077) begin n_err++; $display("FAIL claim_write_data got=%h want=00000077", rs_data_b[31:0]); end
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h00000078;
        tick();
        we = 1'b0;
        #1;
        n_cmp++;
        if (busy_b !== 32'h0 || busy_n !== 32'h0) begin
            n_err++; $display("FAIL write_clears_busy got=%h/%h want=00000000", busy_b, busy_n);
        end
    endtask

    task automatic test_flush;
        claim = 1'b1; claim_addr = 5'd6;
        tick();
        claim = 1'b0;
        #1;
        n_cmp++;
        if (busy_b !== 32'h00000040) begin n_err++; $display("FAIL claim6 got=%h want=00000040", busy_b); end
        claim = 1'b1; claim_addr = 5'd3; flush = 1'b1;
        we = 1'b1; rd_addr = 5'd10; rd_data = 32'h000000A5;
        tick();
        claim = 1'b0; flush = 1'b0; we = 1'b0; rs_addr = {5'd10, 5'd0};
        #1;
        n_cmp++;
        if (busy_b !== 32'h0) begin n_err++; $display("FAIL flush_busy got=%h want=00000000", busy_b); end
        n_cmp++;
        if (rs_data_b[63:32] !== 32'h000000A5) begin n_err++; $display("FAIL flush_write got=%h want=000000a5", rs_data_b[63:32]); end
    endtask

    task automatic test_clear_reset;
        int c;
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h00000055;
        tick();
        we = 1'b0; claim = 1'b1; claim_addr = 5'd2;
        tick();
        claim = 1'b0; rs_addr = {5'd0, 5'd9};
        #1;
        n_cmp++;
        if (rs_data_b[31:0] !== 32'h00000055) begin n_err++; $display("FAIL x9_write got=%h want=00000055", rs_data_b[31:0]); end
        n_cmp++;
        if (busy_b !== 32'h00000004) begin n_err++; $display("FAIL claim2 got=%h want=00000004", busy_b); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        n_cmp++;
        if (ready_b !== 1'b0 || busy_b !== 32'h0) begin
            n_err++; $display("FAIL clear_enter got ready=%b busy=%h want ready=0 busy=0", ready_b, busy_b);
        end
        n_cmp++;
        if (rs_data_b[31:0] !== 32'h0) begin n_err++; $display("FAIL clear_read_zero got=%h want=00000000", rs_data_b[31:0]); end
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h00000077; claim = 1'b1; claim_addr = 5'd9;
        tick();
        tick();
        tick();
        we = 1'b0; claim = 1'b0;
        #1;
        n_cmp++;
        if (busy_b !== 32'h0 || ready_b !== 1'b0) begin
            n_err++; $display("FAIL clear_ignores got ready=%b busy=%h want ready=0 busy=0", ready_b, busy_b);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ready_b !== 1'b0) begin n_err++; $display("FAIL midclear_reset got=%b want=0", ready_b); end
        tick();
        tick();
        rst_n = 1'b1;
        wait_ready(c);
        n_cmp++;
        if (c != 31) begin n_err++; $display("FAIL restart_cycles got=%0d want=31", c); end
        rs_addr = {5'd5, 5'd9}; dbg_addr = 5'd9;
        #1;
        n_cmp++;
        if (rs_data_b[31:0] !== 32'h0 || dbg_b !== 32'h0) begin
            n_err++; $display("FAIL x9_cleared got=%h/%h want=0", rs_data_b[31:0], dbg_b);
        end
        n_cmp++;
        if (rs_data_b[63:32] !== 32'h0) begin n_err++; $display("FAIL x5_cleared got=%h want=00000000", rs_data_b[63:32]); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_debug_no_bypass();
        test_x0();
        test_claim_write();
        test_flush();
        test_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
